rob_retire_ctrl: RTL and testbench

ROB_RETIRE_CTRL -- requirements
Module: rob_retire_ctrl

---
 rtl/rob_retire_ctrl.sv | 152 +++++++++++++++
 tb/tb_rob_retire_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rob_retire_ctrl.sv
// ROB retirement controller: in-order retire of up to N head entries, mispredict flush/drain, halt.
// Optional retired-instruction counter enabled by defining RETIRE_PERF_CNT_EN.
module rob_retire_ctrl #(
    parameter int N            = 3,
    parameter int ROB_SZ       = 32,
    parameter int DRAIN_CYCLES = 2,
    localparam int ROB_SZ_BITS = $clog2(ROB_SZ),
    localparam int CNT_BITS    = $clog2(N + 1)
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic [CNT_BITS-1:0]                 i_head_valid_cnt,
    input  logic [N-1:0]                        i_head_complete,
    input  logic [N-1:0]                        i_head_mispredict,
    input  logic [N-1:0]                        i_head_halt,
    input  logic [N-1:0][ROB_SZ_BITS-1:0]       i_head_ckpt_tail,
    output logic [CNT_BITS-1:0]                 o_num_retiring,
    output logic                                o_tail_restore_valid,
    output logic [ROB_SZ_BITS-1:0]              o_tail_restore,
    output logic                                o_flush,
    output logic                                o_dispatch_stall,
    output logic                                o_halted,
    output logic [31:0]                         o_retired_count
);

    localparam int DRN_BITS = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DRN_BITS-1:0]     r_drain;
    logic [DRN_BITS-1:0]     w_drain_nxt;
    logic [ROB_SZ_BITS-1:0]  r_tail;
    logic [ROB_SZ_BITS-1:0]  w_tail_nxt;

    logic [CNT_BITS-1:0]     w_k;
    logic                    w_last_mis;
    logic                    w_last_halt;
    logic [ROB_SZ_BITS-1:0]  w_last_ckpt;

    // Scan head entries oldest-first; the run ends at the first incomplete/invalid
    // entry, or right after an entry that redirects the machine (mispredict or halt).
    always_comb begin
        logic v_stop;
        v_stop      = 1'b0;
        w_k         = '0;
        w_last_mis  = 1'b0;
        w_last_halt = 1'b0;
        w_last_ckpt = '0;
        for (int i = 0; i < N; i++) begin
            if (!v_stop) begin
                if ((CNT_BITS'(i) < i_head_valid_cnt) && i_head_complete[i]) begin
                    w_k         = CNT_BITS'(i + 1);
                    w_last_mis  = i_head_mispredict[i];
                    w_last_halt = i_head_halt[i];
                    w_last_ckpt = i_head_ckpt_tail[i];
                    v_stop      = i_head_mispredict[i] | i_head_halt[i];
                end else begin
                    v_stop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_drain_nxt          = r_drain;
        w_tail_nxt           = r_tail;
        o_num_retiring       = '0;
        o_flush              = 1'b0;
        o_tail_restore_valid = 1'b0;
        o_dispatch_stall     = 1'b0;
        o_halted             = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_num_retiring = w_k;
                if (w_k != '0) begin
                    if (w_last_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (w_last_mis) begin
                        w_state_nxt = ST_FLUSH;
                        w_tail_nxt  = w_last_ckpt;
                        w_drain_nxt = DRN_BITS'(DRAIN_CYCLES);
                    end
                end
            end
            ST_FLUSH: begin
                o_flush              = 1'b1;
                o_tail_restore_valid = 1'b1;
                o_dispatch_stall     = 1'b1;
                w_state_nxt          = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_dispatch_stall = 1'b1;
                if (r_drain != '0) begin
                    w_drain_nxt = r_drain - 1'b1;
                end
                if (r_drain <= DRN_BITS'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                o_halted         = 1'b1;
                o_dispatch_stall = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        // Nothing may retire while reset is held, whatever the state register says.
        if (!i_reset) begin
            o_num_retiring = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_RUN;
            r_drain <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    assign o_tail_restore = r_tail;

`ifdef RETIRE_PERF_CNT_EN
    logic [31:0] r_retired_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_retired_count <= '0;
        end else begin
            r_retired_count <= r_retired_count + 32'(o_num_retiring);
        end
    end

    assign o_retired_count = r_retired_count;
`else
    assign o_retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Scoreboard bench for rob_retire_ctrl (N=3, ROB_SZ=32, DRAIN_CYCLES=2).
module tb_rob_retire_ctrl;

    logic              clk;
    logic              rst_n;
    logic [1:0]        head_valid_cnt;
    logic [2:0]        head_complete;
    logic [2:0]        head_mispredict;
    logic [2:0]        head_halt;
    logic [2:0][4:0]   head_ckpt_tail;
    logic [1:0]        num_retiring;
    logic              tail_restore_valid;
    logic [4:0]        tail_restore;
    logic              flush;
    logic              dispatch_stall;
    logic              halted;
    logic [31:0]       retired_count;

    rob_retire_ctrl #(
        .N(3),
        .ROB_SZ(32),
        .DRAIN_CYCLES(2)
    ) dut (
        .i_clock              (clk),
        .i_reset              (rst_n),
        .i_head_valid_cnt     (head_valid_cnt),
        .i_head_complete      (head_complete),
        .i_head_mispredict    (head_mispredict),
        .i_head_halt          (head_halt),
        .i_head_ckpt_tail     (head_ckpt_tail),
        .o_num_retiring       (num_retiring),
        .o_tail_restore_valid (tail_restore_valid),
        .o_tail_restore       (tail_restore),
        .o_flush              (flush),
        .o_dispatch_stall     (dispatch_stall),
        .o_halted             (halted),
        .o_retired_count      (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    nret;
        bit    fl;
        bit    trv;
        int    tail;
        bit    stall;
        bit    hlt;
        int    rc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_rc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expected outputs, compare on the falling edge.
    task automatic cyc(input string tag, input bit rstn, input int cnt,
                       input bit [2:0] comp, input bit [2:0] mis, input bit [2:0] hlt,
                       input int e_nret, input bit e_fl, input bit e_trv, input int e_tail,
                       input bit e_stall, input bit e_hlt);
        exp_t e;
        exp_t g;
        rst_n           = rstn;
        head_valid_cnt  = 2'(cnt);
        head_complete   = comp;
        head_mispredict = mis;
        head_halt       = hlt;
        e.tag   = tag;
        e.nret  = e_nret;
        e.fl    = e_fl;
        e.trv   = e_trv;
        e.tail  = e_tail;
        e.stall = e_stall;
        e.hlt   = e_hlt;
`ifdef RETIRE_PERF_CNT_EN
        e.rc    = exp_rc;
`else
        e.rc    = 0;
`endif
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk({g.tag, ".nret"},  32'(num_retiring),       32'(g.nret));
            chk({g.tag, ".flush"}, 32'(flush),              32'(g.fl));
            chk({g.tag, ".trv"},   32'(tail_restore_valid), 32'(g.trv));
            chk({g.tag, ".tail"},  32'(tail_restore),       32'(g.tail));
            chk({g.tag, ".stall"}, 32'(dispatch_stall),     32'(g.stall));
            chk({g.tag, ".halt"},  32'(halted),             32'(g.hlt));
            chk({g.tag, ".rcnt"},  retired_count,           32'(g.rc));
        end
        @(posedge clk);
        if (!rstn) exp_rc = 0;
        else       exp_rc = exp_rc + e_nret;
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        head_valid_cnt  = '0;
        head_complete   = '0;
        head_mispredict = '0;
        head_halt       = '0;
        head_ckpt_tail  = {5'd9, 5'd17, 5'd5};
        @(posedge clk);
        #1;

        // reset held: retire forced to zero even with complete entries
        cyc("rst",     0, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        cyc("all3",    1, 3, 3'b111, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0);
        cyc("gap",     1, 3, 3'b101, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0);
        cyc("cnt2",    1, 2, 3'b111, 3'b000, 3'b000, 2, 0, 0, 0, 0, 0);
        cyc("cnt0",    1, 0, 3'b111, 3'b111, 3'b111, 0, 0, 0, 0, 0, 0);
        cyc("head_nc", 1, 3, 3'b110, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
        cyc("two",     1, 3, 3'b011, 3'b000, 3'b000, 2, 0, 0, 0, 0, 0);
        // halt on an invalid entry must be ignored
        cyc("inv_hlt", 1, 1, 3'b111, 3'b000, 3'b010, 1, 0, 0, 0, 0, 0);
        cyc("run_ok",  1, 3, 3'b001, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0);

        // mispredict on entry 1 with checkpoint 17
        cyc("mis",     1, 3, 3'b111, 3'b010, 3'b000, 2, 0, 0, 0, 0, 0);
        cyc("flush",   1, 3, 3'b111, 3'b000, 3'b000, 0, 1, 1, 17, 1, 0);
        cyc("drain1",  1, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0, 17, 1, 0);
        cyc("drain2",  1, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0, 17, 1, 0);
        cyc("back",    1, 3, 3'b111, 3'b000, 3'b000, 3, 0, 0, 17, 0, 0);

        // mispredict on entry 0 (later halt not reached), then reset during drain
        head_ckpt_tail = {5'd9, 5'd17, 5'd25};
        cyc("mis0",    1, 3, 3'b111, 3'b001, 3'b100, 1, 0, 0, 17, 0, 0);
        cyc("flush0",  1, 3, 3'b111, 3'b000, 3'b000, 0, 1, 1, 25, 1, 0);
        cyc("drn_rst", 0, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0, 25, 1, 0);
        cyc("aft1",    1, 3, 3'b111, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0);
        cyc("aft2",    1, 3, 3'b111, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0);
        cyc("aft3",    1, 3, 3'b111, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0);
        cyc("aft4",    1, 3, 3'b111, 3'b000, 3'b000, 3, 0, 0, 0, 0, 0);

        // halt wins over mispredict on the same entry
        cyc("halt",    1, 3, 3'b111, 3'b001, 3'b001, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("hold%0d", i), 1, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 1, 1);
        end
        cyc("hlt_rst", 0, 3, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 1, 1);
        cyc("post",    1, 2, 3'b011, 3'b000, 3'b000, 2, 0, 0, 0, 0, 0);
        cyc("post2",   1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0);

        if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
